// File: rtl/srt_r2_seq.sv
// Iterative unsigned radix-2 SRT divider: normalize, n digit steps,
// sign correction and remainder denormalization; valid/ready on both sides.
module srt_r2_seq #(
    parameter int WID = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [WID-1:0] op1_i,
    input  logic [WID-1:0] op2_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [WID-1:0] quo_o,
    output logic [WID-1:0] rem_o,
    output logic           div0_o,
    output logic           busy_o
);

    localparam int PW = WID + 3;
    localparam int CW = $clog2(WID + 1);
    localparam logic signed [PW-1:0] LIM  = PW'(2 ** WID);
    localparam logic signed [PW-1:0] NLIM = -LIM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_CORR,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WID-1:0]        a_q, a_d;
    logic [WID-1:0]        d_q, d_d;
    logic signed [PW-1:0]  p_q, p_d;
    logic [WID:0]          dx_q, dx_d;
    logic [WID-1:0]        qp_q, qp_d;
    logic [WID-1:0]        qn_q, qn_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         n_q, n_d;
    logic [WID-1:0]        quo_d, rem_d;
    logic                  div0_d;

    logic signed [PW-1:0]  dx_s;
    logic signed [PW-1:0]  t_c;
    logic signed [PW-1:0]  p_fix;
    logic [WID-1:0]        q_c;
    logic [CW-1:0]         nrm_n;
    logic                  q_pos, q_neg;

    function automatic logic [CW-1:0] lzc(input logic [WID-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < WID; i++) begin
            if (v[i]) r = CW'(WID - 1 - i);
        end
        return r;
    endfunction

    assign nrm_n = lzc(d_q) + CW'(1);
    assign dx_s  = $signed({2'b00, dx_q});
    assign t_c   = p_q <<< 1;
    assign q_pos = (t_c >= LIM);
    assign q_neg = (t_c < NLIM);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        p_d     = p_q;
        dx_d    = dx_q;
        qp_d    = qp_q;
        qn_d    = qn_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        quo_d   = quo_o;
        rem_d   = rem_o;
        div0_d  = div0_o;
        q_c     = qp_q - qn_q;
        p_fix   = p_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid_i && ready_o) begin
                    a_d     = op1_i;
                    d_d     = op2_i;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                p_d   = $signed({3'b000, a_q});
                dx_d  = {1'b0, d_q} << nrm_n;
                qp_d  = '0;
                qn_d  = '0;
                cnt_d = nrm_n;
                n_d   = nrm_n;
                if (d_q == '0) begin
                    quo_d   = '1;
                    rem_d   = a_q;
                    div0_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (q_pos)      p_d = t_c - dx_s;
                else if (q_neg) p_d = t_c + dx_s;
                else            p_d = t_c;
                qp_d  = {qp_q[WID-2:0], q_pos};
                qn_d  = {qn_q[WID-2:0], q_neg};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_CORR;
            end
            S_CORR: begin
                // A negative partial remainder means the last digit overshot
                if (p_q[PW-1]) begin
                    p_fix = p_q + dx_s;
                    q_c   = q_c - WID'(1);
                end
                quo_d   = q_c;
                rem_d   = WID'($unsigned(p_fix) >> n_q);
                div0_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            d_q     <= '0;
            p_q     <= '0;
            dx_q    <= '0;
            qp_q    <= '0;
            qn_q    <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            quo_o   <= '0;
            rem_o   <= '0;
            div0_o  <= 1'b0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            p_q     <= p_d;
            dx_q    <= dx_d;
            qp_q    <= qp_d;
            qn_q    <= qn_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            quo_o   <= quo_d;
            rem_o   <= rem_d;
            div0_o  <= div0_d;
            ready_o <= (state_d == S_IDLE);
            valid_o <= (state_d == S_DONE);
            busy_o  <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_srt_r2_seq.sv
// Directed and random checks for the radix-2 SRT divider controller.
module tb_srt_r2_seq;

    localparam int WID = 8;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           valid_i;
    logic           ready_o;
    logic [WID-1:0] op1_i;
    logic [WID-1:0] op2_i;
    logic           valid_o;
    logic           ready_i;
    logic [WID-1:0] quo_o;
    logic [WID-1:0] rem_o;
    logic           div0_o;
    logic           busy_o;

    int checks = 0;
    int errors = 0;
    int pv;

    srt_r2_seq #(.WID(WID)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op1_i   (op1_i),
        .op2_i   (op2_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .quo_o   (quo_o),
        .rem_o   (rem_o),
        .div0_o  (div0_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lzc8(input logic [7:0] v);
        int r;
        r = 8;
        for (int i = 0; i < 8; i++) if (v[i]) r = 7 - i;
        return r;
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        int w;
        w = 0;
        while (!ready_o && w < 50) begin
            step();
            w++;
        end
        chk("issue_ready", 32'(ready_o), 1);
        op1_i   = a;
        op2_i   = b;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(input bit rnd, output int lat);
        lat = 1;
        while (!valid_o && lat < 60) begin
            if (rnd) ready_i = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
    endtask

    task automatic directed(input string tag, input logic [7:0] a,
                            input logic [7:0] b, input int eq,
                            input int er, input int ed, input int el);
        int lat;
        ready_i = 1'b1;
        issue(a, b);
        wait_valid(1'b0, lat);
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_quo"}, 32'(quo_o), eq);
        chk({tag, "_rem"}, 32'(rem_o), er);
        chk({tag, "_div0"}, 32'(div0_o), ed);
        step();
        chk({tag, "_idle_ready"}, 32'(ready_o), 1);
        chk({tag, "_idle_valid"}, 32'(valid_o), 0);
    endtask

    // |P| <= Dx while digits are being produced and at correction
    always @(negedge clk) begin
        if (!rst_i && (dut.state_q == 3'd2 || dut.state_q == 3'd3)) begin
            pv = int'(dut.p_q);
            if (pv < 0) pv = -pv;
            chk("p_bound", 32'(pv <= int'(dut.dx_q)), 1);
        end
    end

    initial begin
        int lat;
        int w;
        bit hs;
        logic [7:0] a, b;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        op1_i   = '0;
        op2_i   = '0;
        repeat (3) step();
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_quo", 32'(quo_o), 0);
        chk("rst_rem", 32'(rem_o), 0);
        chk("rst_div0", 32'(div0_o), 0);
        rst_i = 1'b0;
        step();

        directed("d100_7", 8'd100, 8'd7, 14, 2, 0, 9);
        directed("d255_1", 8'd255, 8'd1, 255, 0, 0, 11);
        directed("d5_200", 8'd5, 8'd200, 0, 5, 0, 4);
        directed("d37_0", 8'd37, 8'd0, 255, 37, 1, 2);
        directed("d9_3", 8'd9, 8'd3, 3, 0, 0, 10);

        ready_i = 1'b0;
        issue(8'd100, 8'd7);
        wait_valid(1'b0, lat);
        chk("bp_lat", lat, 9);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                op1_i   = 8'd50;
                op2_i   = 8'd5;
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            chk("bp_valid", 32'(valid_o), 1);
            chk("bp_quo", 32'(quo_o), 14);
            chk("bp_rem", 32'(rem_o), 2);
            chk("bp_ready", 32'(ready_o), 0);
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        chk("bp_rel_ready", 32'(ready_o), 1);
        chk("bp_rel_valid", 32'(valid_o), 0);
        chk("bp_rel_busy", 32'(busy_o), 0);
        step();
        chk("bp_ignored_busy", 32'(busy_o), 0);

        issue(8'd200, 8'd3);
        repeat (3) step();
        chk("mid_busy", 32'(busy_o), 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mr_ready", 32'(ready_o), 1);
        chk("mr_valid", 32'(valid_o), 0);
        chk("mr_busy", 32'(busy_o), 0);
        chk("mr_quo", 32'(quo_o), 0);
        chk("mr_rem", 32'(rem_o), 0);
        chk("mr_div0", 32'(div0_o), 0);
        directed("d200_3", 8'd200, 8'd3, 66, 2, 0, 10);

        for (int k = 0; k < 4000; k++) begin
            a = 8'($urandom_range(0, 255));
            if (k % 4 == 0) b = 8'($urandom_range(0, 15));
            else            b = 8'($urandom_range(0, 255));
            issue(a, b);
            wait_valid(1'b1, lat);
            if (b == 8'd0) begin
                chk("rnd_z_div0", 32'(div0_o), 1);
                chk("rnd_z_quo", 32'(quo_o), 255);
                chk("rnd_z_rem", 32'(rem_o), 32'(a));
                chk("rnd_z_lat", lat, 2);
            end else begin
                chk("rnd_ident", 32'(quo_o) * 32'(b) + 32'(rem_o), 32'(a));
                chk("rnd_rem_lt", 32'(rem_o < b), 1);
                chk("rnd_lat", lat, lzc8(b) + 4);
                chk("rnd_div0", 32'(div0_o), 0);
            end
            hs = 1'b0;
            w  = 0;
            while (!hs && w < 40) begin
                ready_i = 1'($urandom_range(0, 2) != 0);
                hs      = ready_i;
                step();
                w++;
            end
            if (!hs) begin
                ready_i = 1'b1;
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
